mca_control_sequencer: RTL and testbench
========================================

# mca_control_sequencer

Front end for the multi-clock FIR adder tree. It collects N-bit control vectors from the CBADC digital control into a K-deep history window. Every OSR accepted vectors it freezes a snapshot of the window as the `S_matrix` the adder consumes, pulses `start`, waits out the adder latency, and captures the finished `sample` with a one-cycle valid strobe.

## Interface

Parameters:
- `K`, 256: history depth (FIR taps); must be at least 2.
- `N`, 8: control bits per vector (analog states).
- `WIDTH_COEFFICIENT`, 32: width of the adder result.
- `OSR`, 8: decimation factor, at least 1. This is the number of accepted vectors between adder starts.
- `ADDER_LATENCY`, 6: number of cycles from the `start` cycle to the cycle in which the adder `sample` is valid. Must be at least 1.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `ctrl_valid`, in, 1: `ctrl_bits` is valid this cycle; the vector is always accepted (no backpressure).
- `ctrl_bits`, in, N: control vector from the digital control.
- `S_matrix`, out, `[N-1:0]` x `[K-1:0]`: frozen snapshot to the adder. Index 0 holds the newest vector and index K-1 the oldest.
- `start`, out, 1: one-cycle pulse to the adder.
- `sample`, in, `WIDTH_COEFFICIENT` (signed): result from the adder.
- `sample_out`, out, `WIDTH_COEFFICIENT` (signed): last captured result.
- `sample_valid`, out, 1: one-cycle strobe when `sample_out` updates.
- `overrun`, out, 1: sticky flag; a trigger arrived while busy.

## Operation

- **History shift.** On each cycle with `ctrl_valid`=1:
  - `hist[0]` <= `ctrl_bits`;
  - `hist[k]` <= `hist[k-1]` for k = 1 to K-1.
  - The history shifts regardless of FSM state.
- **Fill counter.** Width `$clog2(K+1)`. Increments per accepted vector and saturates at K.
- **Decimation counter.** Width `$clog2(OSR)`, minimum 1.
  - Cleared when the fill counter reaches K.
  - Afterwards it increments per accepted vector and wraps from OSR-1 to 0.
- **Trigger.** A combinational signal, true in a cycle where `ctrl_valid`=1 and either:
  - that vector brings the fill counter from K-1 to K, or
  - the window is already full and the decimation counter equals OSR-1.
- **FSM, IDLE state.**
  - On trigger: `S_matrix` <= next-state history (including the vector just accepted), `start` <= 1, latency counter <= 0, go to BUSY.
- **FSM, BUSY state.**
  - The latency counter (width `$clog2(ADDER_LATENCY+1)`) increments every cycle.
  - When it reaches ADDER_LATENCY-1 (the cycle the adder result is valid): `sample_out` <= `sample`, `sample_valid` <= 1, return to IDLE.
  - A trigger in that final BUSY cycle is accepted exactly as in IDLE: snapshot, `start`, stay in BUSY with the counter reset.
  - A trigger in any other BUSY cycle is dropped: `overrun` <= 1, `S_matrix` is unchanged, no `start`, and the decimation count continues.
- **Output stability.**
  - `S_matrix` is held constant between snapshots.
  - `sample_out` holds until the next capture.
  - `overrun` clears only on reset.
- **Data handling.** No arithmetic on `sample`; it is passed through unchanged as a signed value.

## Timing

- **Reset.** While `reset`=1 at an edge:
  - `hist`, `S_matrix`, `sample_out`, and all counters go to 0;
  - `start`, `sample_valid`, and `overrun` go to 0;
  - the FSM goes to IDLE.
- **Reset during BUSY.** The computation is aborted; no `sample_valid` follows. The window must refill with K vectors before the next `start`.
- **Trigger to start.** If the trigger is in cycle t, then in cycle t+1 `start`=1 and the new `S_matrix` is visible. Latency is 1 cycle.
- **Capture.** `sample` is sampled at the end of cycle t+ADDER_LATENCY; `sample_valid`=1 in cycle t+1+ADDER_LATENCY, for exactly one cycle.
- **First start.** Occurs exactly one cycle after the K-th accepted vector following reset.
- **Start spacing.** With `ctrl_valid` continuously high, consecutive starts are exactly OSR cycles apart. Gaps in `ctrl_valid` stretch the spacing without losing count.
- **Overrun condition.** Continuous input never overruns if OSR >= ADDER_LATENCY.

## Test plan

Use K=8, N=4, OSR=2, ADDER_LATENCY=3 unless stated otherwise.

- **Reset values.** Assert `reset` for 2 cycles with `ctrl_valid`=1 -> all outputs 0, no `start`; after release, 7 vectors produce no `start`.
- **Fill.** Feed vectors 0x0 to 0x7 back-to-back -> `start`=1 in the cycle after 0x7; `S_matrix[0]`=0x7 and `S_matrix[7]`=0x0.
- **Capture.** Drive `sample`=0xDEADBEEF only in cycle start+2, 0 otherwise -> `sample_valid`=1 in cycle start+3, `sample_out`=0xDEADBEEF held afterwards. Also drive `sample`=0x80000000 (negative) and check it passes through unchanged.
- **Decimation and overrun.** Keep feeding continuously (OSR=2 < latency) -> second trigger dropped, `overrun`=1, snapshot unchanged. Then insert 1-cycle gaps in `ctrl_valid` -> starts spaced 4 cycles apart, with each snapshot shifted by 2 vectors.
- **Trigger on capture cycle.** ADDER_LATENCY=2, OSR=2, continuous input -> capture and new `start` in adjacent cycles, `overrun` stays 0, every start yields one `sample_valid`.
- **Reset mid-BUSY.** Assert `reset` one cycle after `start` -> no `sample_valid`, `S_matrix`=0, next `start` only after 8 new vectors.

Source files
------------

// File: rtl/mca_control_sequencer.sv
// mca_control_sequencer: collects control vectors into a K-deep history window,
// snapshots it every OSR accepted vectors for the FIR adder tree, pulses start,
// and captures the adder result after its fixed latency.
module mca_control_sequencer #(
   parameter int unsigned K                 = 256,
   parameter int unsigned N                 = 8,
   parameter int unsigned WIDTH_COEFFICIENT = 32,
   parameter int unsigned OSR               = 8,
   parameter int unsigned ADDER_LATENCY     = 6
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                ctrl_valid,
   input  logic [N-1:0]                        ctrl_bits,
   output logic [K-1:0][N-1:0]                 S_matrix,
   output logic                                start,
   input  logic signed [WIDTH_COEFFICIENT-1:0] sample,
   output logic signed [WIDTH_COEFFICIENT-1:0] sample_out,
   output logic                                sample_valid,
   output logic                                overrun
);

   localparam int unsigned FILL_W = $clog2(K + 1);
   localparam int unsigned DEC_W  = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int unsigned LAT_W  = $clog2(ADDER_LATENCY + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                               r_state;
   state_t                               w_state_nxt;
   logic [K-1:0][N-1:0]                  r_hist;
   logic [K-1:0][N-1:0]                  w_hist_nxt;
   logic [K-1:0][N-1:0]                  r_s_matrix;
   logic [FILL_W-1:0]                    r_fill;
   logic [DEC_W-1:0]                     r_dec;
   logic [LAT_W-1:0]                     r_lat;
   logic [LAT_W-1:0]                     w_lat_nxt;
   logic                                 r_start;
   logic                                 r_sample_valid;
   logic                                 r_overrun;
   logic signed [WIDTH_COEFFICIENT-1:0]  r_sample_out;
   logic                                 w_full;
   logic                                 w_trigger;
   logic                                 w_fire;
   logic                                 w_capture;
   logic                                 w_overrun_set;

   // Window after this cycle's vector (newest at index 0), and the decimation trigger
   always_comb begin
      w_hist_nxt = r_hist;
      if (ctrl_valid) begin
         w_hist_nxt = {r_hist[K-2:0], ctrl_bits};
      end
      w_full    = (r_fill == FILL_W'(K));
      w_trigger = ctrl_valid &&
                  ((r_fill == FILL_W'(K - 1)) ||
                   (w_full && (r_dec == DEC_W'(OSR - 1))));
   end

   // Next-state logic: accept triggers in IDLE or the capture cycle, flag all others
   always_comb begin
      w_state_nxt   = r_state;
      w_lat_nxt     = r_lat;
      w_fire        = 1'b0;
      w_capture     = 1'b0;
      w_overrun_set = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_trigger) begin
               w_fire      = 1'b1;
               w_lat_nxt   = '0;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_lat_nxt = r_lat + LAT_W'(1);
            if (r_lat == LAT_W'(ADDER_LATENCY - 1)) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_IDLE;
               if (w_trigger) begin
                  w_fire      = 1'b1;
                  w_lat_nxt   = '0;
                  w_state_nxt = ST_BUSY;
               end
            end else if (w_trigger) begin
               w_overrun_set = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state and latency counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_lat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lat   <= w_lat_nxt;
      end
   end

   // History window, fill/decimation counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist         <= '0;
         r_fill         <= '0;
         r_dec          <= '0;
         r_s_matrix     <= '0;
         r_start        <= 1'b0;
         r_sample_valid <= 1'b0;
         r_sample_out   <= '0;
         r_overrun      <= 1'b0;
      end else begin
         r_hist <= w_hist_nxt;
         if (ctrl_valid) begin
            if (!w_full) begin
               r_fill <= r_fill + FILL_W'(1);
            end
            if (w_full) begin
               r_dec <= (r_dec == DEC_W'(OSR - 1)) ? '0 : r_dec + DEC_W'(1);
            end else begin
               r_dec <= '0;
            end
         end
         if (w_fire) begin
            r_s_matrix <= w_hist_nxt;
         end
         r_start        <= w_fire;
         r_sample_valid <= w_capture;
         if (w_capture) begin
            r_sample_out <= sample;
         end
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign S_matrix     = r_s_matrix;
   assign start        = r_start;
   assign sample_out   = r_sample_out;
   assign sample_valid = r_sample_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_mca_control_sequencer.sv
// Bench for mca_control_sequencer: two instances (adder latency 3 and 2) share
// one random stimulus stream and are compared cycle by cycle with a model that
// works from accepted-vector counts and trigger cycle numbers.
module tb_mca_control_sequencer;

   localparam int unsigned K   = 8;
   localparam int unsigned N   = 4;
   localparam int unsigned W   = 32;
   localparam int unsigned OSR = 2;
   localparam int          AL_A = 3;
   localparam int          AL_B = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             ctrl_valid;
   logic [N-1:0]     ctrl_bits;
   logic [W-1:0]     sample;
   logic [K-1:0][N-1:0] smat_a, smat_b;
   logic             start_a, start_b;
   logic [W-1:0]     sout_a, sout_b;
   logic             sval_a, sval_b;
   logic             ovr_a, ovr_b;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state
   logic [N-1:0] win [K];
   int           cnt;
   int           al      [2];
   int           tstart  [2];
   bit           have    [2];
   bit           e_start [2];
   bit           e_valid [2];
   bit           e_ovr   [2];
   logic [W-1:0] e_sout  [2];
   logic [K*N-1:0] e_smat [2];

   always #5 clk = ~clk;

   mca_control_sequencer #(.K(K), .N(N), .WIDTH_COEFFICIENT(W), .OSR(OSR), .ADDER_LATENCY(AL_A)) u_dut_a (
      .clk(clk), .reset(reset), .ctrl_valid(ctrl_valid), .ctrl_bits(ctrl_bits),
      .S_matrix(smat_a), .start(start_a), .sample(sample), .sample_out(sout_a),
      .sample_valid(sval_a), .overrun(ovr_a));

   mca_control_sequencer #(.K(K), .N(N), .WIDTH_COEFFICIENT(W), .OSR(OSR), .ADDER_LATENCY(AL_B)) u_dut_b (
      .clk(clk), .reset(reset), .ctrl_valid(ctrl_valid), .ctrl_bits(ctrl_bits),
      .S_matrix(smat_b), .start(start_b), .sample(sample), .sample_out(sout_b),
      .sample_valid(sval_b), .overrun(ovr_b));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Model of one clock edge: what every output should show after it
   task automatic model_step(input logic r, input logic v, input logic [N-1:0] b, input logic [W-1:0] s);
      bit trig;
      bit busy;
      bit last;
      logic [K*N-1:0] snap;
      if (r) begin
         for (int k = 0; k < K; k++) win[k] = '0;
         cnt = 0;
         for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0; tstart[i] = 0; e_start[i] = 1'b0; e_valid[i] = 1'b0;
            e_ovr[i] = 1'b0; e_sout[i] = '0; e_smat[i] = '0;
         end
         return;
      end
      trig = 1'b0;
      if (v) begin
         for (int k = K - 1; k > 0; k--) win[k] = win[k-1];
         win[0] = b;
         cnt++;
         trig = (cnt == K) || (cnt > K && ((cnt - K) % OSR) == 0);
      end
      snap = '0;
      for (int k = 0; k < K; k++) snap[k*N +: N] = win[k];
      for (int i = 0; i < 2; i++) begin
         busy = have[i] && cyc >= tstart[i] + 1 && cyc <= tstart[i] + al[i];
         last = have[i] && cyc == tstart[i] + al[i];
         e_start[i] = 1'b0;
         e_valid[i] = 1'b0;
         if (last) begin
            e_valid[i] = 1'b1;
            e_sout[i]  = s;
         end
         if (trig) begin
            if (!busy || last) begin
               e_start[i] = 1'b1;
               e_smat[i]  = snap;
               tstart[i]  = cyc;
               have[i]    = 1'b1;
            end else begin
               e_ovr[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("start_a",  64'(start_a), 64'(e_start[0]));
      chk("valid_a",  64'(sval_a),  64'(e_valid[0]));
      chk("ovr_a",    64'(ovr_a),   64'(e_ovr[0]));
      chk("sout_a",   64'(sout_a),  64'(e_sout[0]));
      chk("smat_a",   64'(smat_a),  64'(e_smat[0]));
      chk("start_b",  64'(start_b), 64'(e_start[1]));
      chk("valid_b",  64'(sval_b),  64'(e_valid[1]));
      chk("ovr_b",    64'(ovr_b),   64'(e_ovr[1]));
      chk("sout_b",   64'(sout_b),  64'(e_sout[1]));
      chk("smat_b",   64'(smat_b),  64'(e_smat[1]));
   endtask

   task automatic cycle(input logic r, input logic v, input logic [N-1:0] b, input logic [W-1:0] s);
      reset = r; ctrl_valid = v; ctrl_bits = b; sample = s;
      model_step(r, v, b, s);
      @(posedge clk);
      #1;
      compare_all();
      cyc++;
   endtask

   function automatic logic [W-1:0] rand_sample();
      case ($urandom_range(0, 3))
         0:       return 32'hDEADBEEF;
         1:       return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      al[0] = AL_A;
      al[1] = AL_B;
      // Reset with valid high, then a back-to-back fill of 0..7 and continuous feed
      cycle(1'b1, 1'b1, 4'hA, 32'h0);
      cycle(1'b1, 1'b1, 4'h5, 32'h0);
      for (int i = 0; i < K; i++) cycle(1'b0, 1'b1, 4'(i), rand_sample());
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'($urandom), rand_sample());
      // One-cycle gaps in ctrl_valid
      for (int i = 0; i < 24; i++) cycle(1'b0, 1'(i % 2), 4'($urandom), rand_sample());
      // Reset one cycle after a start
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b1, 4'($urandom), rand_sample());
         if (start_a) begin
            cycle(1'b0, 1'b1, 4'($urandom), rand_sample());
            cycle(1'b1, 1'b1, 4'($urandom), rand_sample());
            break;
         end
      end
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 4'($urandom), rand_sample());
      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 149) == 0),
               1'($urandom_range(0, 99) < ((i < 300) ? 90 : 55)),
               4'($urandom), rand_sample());
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
